// File: rtl/fir_sequencer.sv
// fir_sequencer: central controller for the FIR demo datapath.
// Debounces the start/stop button into a run flag, paces samples with a
// prescaled tick, launches BCD conversions with a start/done handshake,
// latches the nine result digits and pages them onto three 7-seg digits.
module fir_sequencer #(
  parameter int SAMPLE_DIV   = 50000000,
  parameter int PAGE_DWELL   = 12500000,
  parameter int DEBOUNCE     = 500000,
  parameter int CONV_TIMEOUT = 1024
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        toggle_btn,
  output logic        run,
  output logic        lfsr_rst,
  output logic        sample_tick,
  output logic        conv_start,
  input  logic        conv_done,
  input  logic [35:0] bcd_in,
  output logic [11:0] seg_bcd,
  output logic [1:0]  page,
  output logic        data_valid,
  output logic        overrun,
  output logic        conv_err
);

  // Counter widths; each counter only ever holds 0..LIMIT-1.
  localparam int DB_W  = (DEBOUNCE     > 1) ? $clog2(DEBOUNCE)     : 1;
  localparam int PRE_W = (SAMPLE_DIV   > 1) ? $clog2(SAMPLE_DIV)   : 1;
  localparam int DW_W  = (PAGE_DWELL   > 1) ? $clog2(PAGE_DWELL)   : 1;
  localparam int TO_W  = (CONV_TIMEOUT > 1) ? $clog2(CONV_TIMEOUT) : 1;

  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE - 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SAMPLE_DIV - 1);
  localparam logic [DW_W-1:0]  DW_MAX  = DW_W'(PAGE_DWELL - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(CONV_TIMEOUT - 1);

  // Sequencer states
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_READY   = 2'd1;
  localparam logic [1:0] S_SETTLE  = 2'd2;
  localparam logic [1:0] S_CONVERT = 2'd3;

  // ---------------------------------------------------------------------
  // Button synchronizer and debouncer
  // ---------------------------------------------------------------------
  logic            btn_s1, btn_s2;
  logic            btn_db;     // debounced level, 1 = released
  logic [DB_W-1:0] db_cnt;
  logic            press_evt;

  // Two-flop synchronizer; idles high because the button is active-low.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
    end else begin
      btn_s1 <= toggle_btn;
      btn_s2 <= btn_s1;
    end
  end

  // A press is a synchronized low that has differed from the debounced
  // level for DEBOUNCE consecutive cycles; releases only update btn_db.
  assign press_evt = (btn_s2 != btn_db) && (db_cnt == DB_MAX) && !btn_s2;

  // Stability counter: any return to the debounced level clears it, so the
  // count always restarts when the synchronized level changes.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_s2 == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_MAX) begin
      btn_db <= btn_s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Run flag flips once per debounced press; LFSR reset follows ~run.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      lfsr_rst <= 1'b1;
    end else begin
      run      <= run ^ press_evt;
      lfsr_rst <= ~run;
    end
  end

  // ---------------------------------------------------------------------
  // Sample prescaler
  // ---------------------------------------------------------------------
  logic [PRE_W-1:0] pre_cnt;

  // Counts only while running; the first tick lands SAMPLE_DIV cycles
  // after run rises because the count starts from a cleared state.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      sample_tick <= 1'b0;
    end else if (!run) begin
      pre_cnt     <= '0;
      sample_tick <= 1'b0;
    end else if (pre_cnt == PRE_MAX) begin
      pre_cnt     <= '0;
      sample_tick <= 1'b1;
    end else begin
      pre_cnt     <= pre_cnt + 1'b1;
      sample_tick <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Conversion sequencer
  // ---------------------------------------------------------------------
  logic [1:0]      state;
  logic [TO_W-1:0] to_cnt;
  logic [35:0]     shadow;
  logic            busy;

  // A tick that lands while a conversion is in flight is dropped.
  assign busy = (state == S_SETTLE) || (state == S_CONVERT);

  // Stopping overrides everything: the pending conversion is abandoned and
  // a late conv_done is ignored because the CONVERT branch is not reached.
  // Flags are cleared on the way out of IDLE so they cover one run only.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      to_cnt     <= '0;
      conv_start <= 1'b0;
      shadow     <= {9{4'hF}};
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      conv_err   <= 1'b0;
    end else if (!run) begin
      state      <= S_IDLE;
      to_cnt     <= '0;
      conv_start <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      if (sample_tick && busy)
        overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          overrun    <= 1'b0;
          conv_err   <= 1'b0;
          data_valid <= 1'b0;
          state      <= S_READY;
        end
        S_READY: begin
          if (sample_tick)
            state <= S_SETTLE;
        end
        // One cycle for the moving-average output to register.
        S_SETTLE: begin
          conv_start <= 1'b1;
          to_cnt     <= '0;
          state      <= S_CONVERT;
        end
        // conv_done is tested first so it wins over a coincident timeout.
        S_CONVERT: begin
          if (conv_done) begin
            shadow     <= bcd_in;
            data_valid <= 1'b1;
            state      <= S_READY;
          end else if (to_cnt == TO_MAX) begin
            conv_err <= 1'b1;
            state    <= S_READY;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Display pager
  // ---------------------------------------------------------------------
  logic [DW_W-1:0] dwell;
  logic [11:0]     seg_nxt;

  // Select the three digits for the current page; blank until data exists.
  always_comb begin
    seg_nxt = 12'hFFF;
    if (data_valid) begin
      case (page)
        2'd1:    seg_nxt = shadow[35:24];
        2'd2:    seg_nxt = shadow[23:12];
        2'd3:    seg_nxt = shadow[11:0];
        default: seg_nxt = 12'hFFF;
      endcase
    end
  end

  // Page rotation and registered digit output. seg_bcd samples the page
  // register, so it trails a page change by one cycle, and a shadow update
  // shows up without disturbing the dwell timer.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      dwell   <= '0;
      page    <= 2'd0;
      seg_bcd <= 12'hFFF;
    end else if (!run) begin
      dwell   <= '0;
      page    <= 2'd0;
      seg_bcd <= 12'hFFF;
    end else begin
      if (dwell == DW_MAX) begin
        dwell <= '0;
        page  <= page + 2'd1;
      end else begin
        dwell <= dwell + 1'b1;
      end
      seg_bcd <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer with small parameters. Timelines are
// indexed by k = falling edges since run was first seen changing.
module tb_fir_sequencer;
  logic        CLOCK_50   = 1'b0;
  logic        rst_n      = 1'b1;
  logic        toggle_btn = 1'b1;
  logic        conv_done  = 1'b0;
  logic [35:0] bcd_in     = '0;
  logic        run, lfsr_rst, sample_tick, conv_start;
  logic        data_valid, overrun, conv_err;
  logic [11:0] seg_bcd;
  logic [1:0]  page;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   k       = 0;
  int   rises   = 0;
  logic run_q   = 1'b0;

  fir_sequencer #(
    .SAMPLE_DIV(8), .PAGE_DWELL(4), .DEBOUNCE(3), .CONV_TIMEOUT(16)
  ) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .toggle_btn(toggle_btn),
    .run(run), .lfsr_rst(lfsr_rst), .sample_tick(sample_tick),
    .conv_start(conv_start), .conv_done(conv_done), .bcd_in(bcd_in),
    .seg_bcd(seg_bcd), .page(page), .data_valid(data_valid),
    .overrun(overrun), .conv_err(conv_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Count run rising edges for the bounce test.
  always @(posedge CLOCK_50) begin
    run_q <= run;
    if (run === 1'b1 && run_q === 1'b0) rises <= rises + 1;
  end

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hold the button low until run reaches `want` (bounded), then release.
  task automatic press_wait(input logic want);
    int n;
    n = 0;
    toggle_btn = 1'b0;
    while (run !== want && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("press_run", run, want);
    toggle_btn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    chk("rst_run",   run, 1'b0);
    chk("rst_lfsr",  lfsr_rst, 1'b1);
    chk("rst_tick",  sample_tick, 1'b0);
    chk("rst_start", conv_start, 1'b0);
    chk("rst_seg",   seg_bcd, 12'hFFF);
    chk("rst_page",  page, 2'd0);
    chk("rst_dv",    data_valid, 1'b0);
    chk("rst_ovr",   overrun, 1'b0);
    chk("rst_err",   conv_err, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    chk("idle_run", run, 1'b0);

    // Bounce: 2-cycle toggles never qualify, then a long hold gives one rise
    for (int i = 0; i < 5; i++) begin
      toggle_btn = 1'b0; repeat (2) @(negedge CLOCK_50);
      toggle_btn = 1'b1; repeat (2) @(negedge CLOCK_50);
    end
    chk("bounce_norise", rises, 0);
    toggle_btn = 1'b0; repeat (10) @(negedge CLOCK_50);
    chk("bounce_rises", rises, 1);
    chk("bounce_run", run, 1'b1);
    toggle_btn = 1'b1; repeat (8) @(negedge CLOCK_50);
    toggle_btn = 1'b0; repeat (2) @(negedge CLOCK_50);
    toggle_btn = 1'b1; repeat (8) @(negedge CLOCK_50);
    chk("glitch_run", run, 1'b1);
    chk("glitch_rises", rises, 1);

    // Stop, then start run A
    press_wait(1'b0);
    repeat (8) @(negedge CLOCK_50);
    press_wait(1'b1);
    k = 0;
    while (k < 44) begin
      @(negedge CLOCK_50);
      k++;
      case (k)
        5:  chk("a_seg_nodata", seg_bcd, 12'hFFF);
        7:  chk("a_tick_pre", sample_tick, 1'b0);
        8:  chk("a_tick", sample_tick, 1'b1);
        9:  begin
              chk("a_tick_post", sample_tick, 1'b0);
              chk("a_start_pre", conv_start, 1'b0);
            end
        10: chk("a_start", conv_start, 1'b1);
        11: begin
              chk("a_start_post", conv_start, 1'b0);
              conv_done = 1'b1;
              bcd_in    = 36'h012345678;
            end
        12: begin
              conv_done = 1'b0;
              chk("a_dv", data_valid, 1'b1);
              chk("a_err0", conv_err, 1'b0);
            end
        20: chk("a_page1", page, 2'd1);
        21: chk("a_seg012", seg_bcd, 12'h012);
        24: begin
              chk("a_page2", page, 2'd2);
              chk("a_ovr0", overrun, 1'b0);
            end
        25: begin
              chk("a_seg345", seg_bcd, 12'h345);
              chk("a_ovr1", overrun, 1'b1);
            end
        26: chk("a_drop_start", conv_start, 1'b0);
        29: chk("a_seg678", seg_bcd, 12'h678);
        33: begin
              chk("a_segblank", seg_bcd, 12'hFFF);
              chk("a_err_pre", conv_err, 1'b0);
            end
        34: chk("a_err_timeout", conv_err, 1'b1);
        37: chk("a_shadow_kept", seg_bcd, 12'h012);
        42: chk("a_restart_conv", conv_start, 1'b1);
        default: ;
      endcase
    end

    // Stop mid-conversion; the late conv_done must be ignored
    press_wait(1'b0);
    conv_done = 1'b1;
    bcd_in    = 36'h999999999;
    repeat (2) @(negedge CLOCK_50);
    conv_done = 1'b0;
    @(negedge CLOCK_50);
    chk("stop_run",   run, 1'b0);
    chk("stop_lfsr",  lfsr_rst, 1'b1);
    chk("stop_seg",   seg_bcd, 12'hFFF);
    chk("stop_page",  page, 2'd0);
    chk("stop_start", conv_start, 1'b0);
    repeat (8) @(negedge CLOCK_50);

    // Run B: flags cleared, overrun with a late conv_done
    press_wait(1'b1);
    k = 0;
    while (k < 28) begin
      @(negedge CLOCK_50);
      k++;
      case (k)
        2:  begin
              chk("b_dv_clr",  data_valid, 1'b0);
              chk("b_ovr_clr", overrun, 1'b0);
              chk("b_err_clr", conv_err, 1'b0);
              chk("b_lfsr",    lfsr_rst, 1'b0);
            end
        10: chk("b_start", conv_start, 1'b1);
        16: chk("b_ovr0", overrun, 1'b0);
        17: chk("b_ovr1", overrun, 1'b1);
        18: chk("b_no_start", conv_start, 1'b0);
        19: begin
              conv_done = 1'b1;
              bcd_in    = 36'h123456789;
            end
        20: begin
              conv_done = 1'b0;
              chk("b_dv", data_valid, 1'b1);
              chk("b_err0", conv_err, 1'b0);
            end
        22: chk("b_seg123", seg_bcd, 12'h123);
        25: chk("b_seg456", seg_bcd, 12'h456);
        26: chk("b_start2", conv_start, 1'b1);
        default: ;
      endcase
    end

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_run",  run, 1'b0);
    chk("arst_lfsr", lfsr_rst, 1'b1);
    chk("arst_seg",  seg_bcd, 12'hFFF);
    chk("arst_page", page, 2'd0);
    chk("arst_dv",   data_valid, 1'b0);
    chk("arst_ovr",  overrun, 1'b0);
    #4 rst_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
